// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared DRAM-cache widths, address layout and victim entry type
package dcache_pkg;
    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 512;
    localparam int ID_W     = 16;
    localparam int TAG_W    = 32;
    localparam int INDEX_W  = 26;
    localparam int OFFSET_W = 6;

    localparam int TAG_LSB    = 32;
    localparam int INDEX_LSB  = 6;
    localparam int OFFSET_LSB = 0;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
        logic [DATA_W-1:0]  data;
        logic [ID_W-1:0]    id;
    } evict_entry_t;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction
endpackage

// File: rtl/cxl_evict_match.sv
// rtl/cxl_evict_match.sv - youngest-first tag/index search over occupied buffer entries
module evict_match #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 32,
    parameter int INDEX_W = 26,
    parameter int DATA_W  = 512
) (
    input  logic [DEPTH-1:0]              mask_i,
    input  logic [$clog2(DEPTH)-1:0]      alloc_i,
    input  logic [TAG_W-1:0]              key_tag_i,
    input  logic [INDEX_W-1:0]            key_index_i,
    input  logic [DEPTH-1:0][TAG_W-1:0]   tags_i,
    input  logic [DEPTH-1:0][INDEX_W-1:0] indexes_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]  datas_i,
    output logic                          hit_o,
    output logic [DATA_W-1:0]             data_o
);
    import dcache_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk backwards from the newest slot (alloc-1) so duplicates resolve to the youngest copy.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            idx = alloc_i - PTR_W'(i);
            if (!hit_o && mask_i[idx] && tags_i[idx] == key_tag_i &&
                indexes_i[idx] == key_index_i) begin
                hit_o  = 1'b1;
                data_o = datas_i[idx];
            end
        end
    end
endmodule

// File: rtl/cxl_evict_writer.sv
// rtl/cxl_evict_writer.sv - dirty-victim write-back buffer issuing AW/W/B to the CXL port
module cxl_evict_writer #(
    parameter int DEPTH   = 4,
    parameter int ID_W    = 16,
    parameter int TAG_W   = 32,
    parameter int INDEX_W = 26,
    parameter int DATA_W  = 512
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ev_valid_i,
    output logic               ev_ready_o,
    input  logic [TAG_W-1:0]   ev_tag_i,
    input  logic [INDEX_W-1:0] ev_index_i,
    input  logic [DATA_W-1:0]  ev_data_i,
    output logic [ID_W-1:0]    c_awid_o,
    output logic [63:0]        c_awaddr_o,
    output logic               c_awvalid_o,
    input  logic               c_awready_i,
    output logic [ID_W-1:0]    c_wid_o,
    output logic [DATA_W-1:0]  c_wdata_o,
    output logic               c_wvalid_o,
    input  logic               c_wready_i,
    input  logic [ID_W-1:0]    c_bid_i,
    input  logic               c_bvalid_i,
    output logic               c_bready_o,
    input  logic [TAG_W-1:0]   chk_tag_i,
    input  logic [INDEX_W-1:0] chk_index_i,
    output logic               chk_hit_o,
    output logic [DATA_W-1:0]  chk_data_o,
    output logic               busy_o,
    output logic               err_o
);
    import dcache_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][TAG_W-1:0]   tag_q, tag_d;
    logic [DEPTH-1:0][INDEX_W-1:0] index_q, index_d;
    logic [DEPTH-1:0][DATA_W-1:0]  data_q, data_d;
    logic [DEPTH-1:0][ID_W-1:0]    id_q, id_d;
    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [DEPTH-1:0]              aw_done_q, aw_done_d;
    logic [DEPTH-1:0]              w_done_q, w_done_d;
    logic [PTR_W-1:0]              alloc_q, alloc_d, aw_q, aw_d, w_q, w_d, ret_q, ret_d;
    logic [OCC_W-1:0]              occ_q, occ_d;
    logic [ID_W-1:0]               id_cnt_q, id_cnt_d;
    logic                          err_q, err_d;
    logic                          push, aw_fire, w_fire, b_fire;

    // All valids come from registered state only, so no ready input reaches a valid output.
    assign ev_ready_o  = occ_q < OCC_W'(DEPTH);
    assign c_awvalid_o = valid_q[aw_q] & ~aw_done_q[aw_q];
    assign c_awid_o    = id_q[aw_q];
    assign c_awaddr_o  = 64'({tag_q[aw_q], index_q[aw_q], {OFFSET_W{1'b0}}});
    assign c_wvalid_o  = valid_q[w_q] & ~w_done_q[w_q];
    assign c_wid_o     = id_q[w_q];
    assign c_wdata_o   = data_q[w_q];
    assign c_bready_o  = valid_q[ret_q] & aw_done_q[ret_q] & w_done_q[ret_q];
    assign busy_o      = occ_q != '0;
    assign err_o       = err_q;

    assign push    = ev_valid_i & ev_ready_o;
    assign aw_fire = c_awvalid_o & c_awready_i;
    assign w_fire  = c_wvalid_o & c_wready_i;
    assign b_fire  = c_bvalid_i & c_bready_o;

    // Push, AW, W and retire always touch distinct slots, so their updates never collide.
    always_comb begin
        tag_d     = tag_q;
        index_d   = index_q;
        data_d    = data_q;
        id_d      = id_q;
        valid_d   = valid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        alloc_d   = alloc_q;
        aw_d      = aw_q;
        w_d       = w_q;
        ret_d     = ret_q;
        id_cnt_d  = id_cnt_q;
        err_d     = err_q;
        occ_d     = occ_q;
        if (push) begin
            tag_d[alloc_q]     = ev_tag_i;
            index_d[alloc_q]   = ev_index_i;
            data_d[alloc_q]    = ev_data_i;
            id_d[alloc_q]      = id_cnt_q;
            valid_d[alloc_q]   = 1'b1;
            aw_done_d[alloc_q] = 1'b0;
            w_done_d[alloc_q]  = 1'b0;
            alloc_d            = alloc_q + PTR_W'(1);
            id_cnt_d           = id_cnt_q + ID_W'(1);
        end
        if (aw_fire) begin
            aw_done_d[aw_q] = 1'b1;
            aw_d            = aw_q + PTR_W'(1);
        end
        if (w_fire) begin
            w_done_d[w_q] = 1'b1;
            w_d           = w_q + PTR_W'(1);
        end
        if (b_fire) begin
            valid_d[ret_q] = 1'b0;
            ret_d          = ret_q + PTR_W'(1);
            if (c_bid_i != id_q[ret_q]) begin
                err_d = 1'b1;
            end
        end
        case ({push, b_fire})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q     <= '0;
            index_q   <= '0;
            data_q    <= '0;
            id_q      <= '0;
            valid_q   <= '0;
            aw_done_q <= '0;
            w_done_q  <= '0;
            alloc_q   <= '0;
            aw_q      <= '0;
            w_q       <= '0;
            ret_q     <= '0;
            occ_q     <= '0;
            id_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            index_q   <= index_d;
            data_q    <= data_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            alloc_q   <= alloc_d;
            aw_q      <= aw_d;
            w_q       <= w_d;
            ret_q     <= ret_d;
            occ_q     <= occ_d;
            id_cnt_q  <= id_cnt_d;
            err_q     <= err_d;
        end
    end

    evict_match #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .INDEX_W(INDEX_W),
        .DATA_W (DATA_W)
    ) u_match (
        .mask_i     (valid_q),
        .alloc_i    (alloc_q),
        .key_tag_i  (chk_tag_i),
        .key_index_i(chk_index_i),
        .tags_i     (tag_q),
        .indexes_i  (index_q),
        .datas_i    (data_q),
        .hit_o      (chk_hit_o),
        .data_o     (chk_data_o)
    );
endmodule

// File: tb/tb_cxl_evict_writer.sv
// tb/tb_cxl_evict_writer.sv - self-checking bench for cxl_evict_writer
module tb_cxl_evict_writer;
    import dcache_pkg::*;

    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ev_valid_i;
    logic               ev_ready_o;
    logic [TAG_W-1:0]   ev_tag_i;
    logic [INDEX_W-1:0] ev_index_i;
    logic [DATA_W-1:0]  ev_data_i;
    logic [ID_W-1:0]    c_awid_o;
    logic [63:0]        c_awaddr_o;
    logic               c_awvalid_o;
    logic               c_awready_i;
    logic [ID_W-1:0]    c_wid_o;
    logic [DATA_W-1:0]  c_wdata_o;
    logic               c_wvalid_o;
    logic               c_wready_i;
    logic [ID_W-1:0]    c_bid_i;
    logic               c_bvalid_i;
    logic               c_bready_o;
    logic [TAG_W-1:0]   chk_tag_i;
    logic [INDEX_W-1:0] chk_index_i;
    logic               chk_hit_o;
    logic [DATA_W-1:0]  chk_data_o;
    logic               busy_o;
    logic               err_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] index;
        logic               hit;
        logic [DATA_W-1:0]  data;
    } lk_vec_t;

    lk_vec_t tbl [5];

    cxl_evict_writer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ev_valid_i(ev_valid_i), .ev_ready_o(ev_ready_o),
        .ev_tag_i(ev_tag_i), .ev_index_i(ev_index_i), .ev_data_i(ev_data_i),
        .c_awid_o(c_awid_o), .c_awaddr_o(c_awaddr_o), .c_awvalid_o(c_awvalid_o),
        .c_awready_i(c_awready_i),
        .c_wid_o(c_wid_o), .c_wdata_o(c_wdata_o), .c_wvalid_o(c_wvalid_o),
        .c_wready_i(c_wready_i),
        .c_bid_i(c_bid_i), .c_bvalid_i(c_bvalid_i), .c_bready_o(c_bready_o),
        .chk_tag_i(chk_tag_i), .chk_index_i(chk_index_i),
        .chk_hit_o(chk_hit_o), .chk_data_o(chk_data_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ev_valid_i  = 1'b0;
        ev_tag_i    = '0;
        ev_index_i  = '0;
        ev_data_i   = '0;
        c_awready_i = 1'b0;
        c_wready_i  = 1'b0;
        c_bid_i     = '0;
        c_bvalid_i  = 1'b0;
        chk_tag_i   = '0;
        chk_index_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_one(input logic [TAG_W-1:0] t, input logic [INDEX_W-1:0] i,
                            input logic [DATA_W-1:0] d);
        ev_valid_i = 1'b1;
        ev_tag_i   = t;
        ev_index_i = i;
        ev_data_i  = d;
        tick();
        ev_valid_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_ev_ready"}, ev_ready_o, 1'b1);
        chk({pfx, "_awvalid"}, c_awvalid_o, 1'b0);
        chk({pfx, "_wvalid"}, c_wvalid_o, 1'b0);
        chk({pfx, "_bready"}, c_bready_o, 1'b0);
        chk({pfx, "_busy"}, busy_o, 1'b0);
        chk({pfx, "_err"}, err_o, 1'b0);
        chk({pfx, "_awid"}, c_awid_o, '0);
        chk({pfx, "_awaddr"}, c_awaddr_o, '0);
        chk({pfx, "_wid"}, c_wid_o, '0);
        chk({pfx, "_wdata"}, c_wdata_o, '0);
    endtask

    function automatic logic [DATA_W-1:0] fill(input logic [31:0] w);
        return {16{w}};
    endfunction

    function automatic logic [DATA_W-1:0] rnd512();
        logic [DATA_W-1:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        int retired;
        logic fire;

        // Reset values
        do_reset();
        check_reset_outputs("reset");
        chk("reset_hit", chk_hit_o, 1'b0);
        chk("reset_chk_data", chk_data_o, '0);

        // Single eviction: visible one cycle after the push
        push_one(32'h7, 26'h1, fill(32'haaaaaaaa));
        chk("single_awvalid", c_awvalid_o, 1'b1);
        chk("single_wvalid", c_wvalid_o, 1'b1);
        chk("single_awaddr", c_awaddr_o, 64'h0000000700000040);
        chk("single_awid", c_awid_o, 16'h0);
        chk("single_wdata", c_wdata_o, fill(32'haaaaaaaa));
        chk_tag_i = 32'h7; chk_index_i = 26'h1; #1;
        chk("single_hit", chk_hit_o, 1'b1);
        chk("single_fwd", chk_data_o, fill(32'haaaaaaaa));
        c_awready_i = 1'b1; c_wready_i = 1'b1;
        tick();
        c_awready_i = 1'b0; c_wready_i = 1'b0;
        chk("single_bready", c_bready_o, 1'b1);
        chk("single_aw_gone", c_awvalid_o, 1'b0);
        c_bvalid_i = 1'b1; c_bid_i = 16'h0;
        tick();
        c_bvalid_i = 1'b0;
        chk("single_busy", busy_o, 1'b0);
        chk("single_err", err_o, 1'b0);
        chk("single_hit_gone", chk_hit_o, 1'b0);

        // Full buffer and in-order AW drain
        do_reset();
        for (int k = 0; k < DEPTH; k++) push_one(TAG_W'(k + 1), INDEX_W'(k), fill(32'(k)));
        chk("full_ready_low", ev_ready_o, 1'b0);
        push_one(32'h99, 26'h9, fill(32'h99));
        chk("full_held", ev_ready_o, 1'b0);
        chk("full_busy", busy_o, 1'b1);
        c_awready_i = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("full_awvalid%0d", k), c_awvalid_o, 1'b1);
            chk($sformatf("full_awid%0d", k), c_awid_o, ID_W'(k));
            chk($sformatf("full_awaddr%0d", k), c_awaddr_o, line_addr(TAG_W'(k + 1), INDEX_W'(k)));
            tick();
        end
        chk("full_no_fifth", c_awvalid_o, 1'b0);
        c_awready_i = 1'b0;

        // W ahead of AW
        do_reset();
        c_wready_i = 1'b1;
        for (int k = 0; k < 3; k++) push_one(TAG_W'(k), 26'h2, fill(32'h5));
        tick();
        tick();
        chk("wfirst_wdone", c_wvalid_o, 1'b0);
        chk("wfirst_bready", c_bready_o, 1'b0);
        chk("wfirst_awpend", c_awvalid_o, 1'b1);
        c_awready_i = 1'b1;
        tick();
        chk("wfirst_bready_after_aw", c_bready_o, 1'b1);

        // B id mismatch is sticky, entry still retires
        do_reset();
        c_awready_i = 1'b1; c_wready_i = 1'b1;
        push_one(32'h1, 26'h1, fill(32'h1));
        tick();
        c_awready_i = 1'b0; c_wready_i = 1'b0;
        chk("idmm_bready", c_bready_o, 1'b1);
        c_bvalid_i = 1'b1; c_bid_i = 16'h5;
        tick();
        c_bvalid_i = 1'b0;
        chk("idmm_err", err_o, 1'b1);
        chk("idmm_retired", busy_o, 1'b0);
        repeat (3) tick();
        chk("idmm_sticky", err_o, 1'b1);

        // Forwarding: youngest duplicate wins
        do_reset();
        push_one(32'hf, 26'h1, fill(32'hbbbbbbbb));
        push_one(32'hf, 26'h1, fill(32'hcccccccc));
        push_one(32'h3, 26'h9, fill(32'hdddddddd));
        tbl[0] = '{32'hf, 26'h1, 1'b1, fill(32'hcccccccc)};
        tbl[1] = '{32'hf, 26'h2, 1'b0, '0};
        tbl[2] = '{32'h3, 26'h9, 1'b1, fill(32'hdddddddd)};
        tbl[3] = '{32'he, 26'h1, 1'b0, '0};
        tbl[4] = '{32'h3, 26'h1, 1'b0, '0};
        for (int k = 0; k < 5; k++) begin
            chk_tag_i = tbl[k].tag; chk_index_i = tbl[k].index; #1;
            chk($sformatf("fwd_hit%0d", k), chk_hit_o, tbl[k].hit);
            chk($sformatf("fwd_data%0d", k), chk_data_o, tbl[k].data);
        end
        c_awready_i = 1'b1; c_wready_i = 1'b1;
        retired = 0;
        for (int cyc = 0; cyc < 30 && retired < 3; cyc++) begin
            c_bid_i = ID_W'(retired); c_bvalid_i = 1'b1; #1;
            fire = c_bready_o;
            tick();
            if (fire) retired++;
        end
        c_bvalid_i = 1'b0; c_awready_i = 1'b0; c_wready_i = 1'b0;
        chk("fwd_drain_done", 32'(retired), 32'd3);
        chk_tag_i = 32'hf; chk_index_i = 26'h1; #1;
        chk("fwd_after_hit", chk_hit_o, 1'b0);
        chk("fwd_after_data", chk_data_o, '0);
        chk("fwd_after_err", err_o, 1'b0);

        // Reset with entries outstanding
        do_reset();
        push_one(32'h11, 26'h3, fill(32'h11));
        push_one(32'h12, 26'h4, fill(32'h12));
        chk("rst_mid_busy", busy_o, 1'b1);
        rst_n = 1'b0; #1;
        check_reset_outputs("rst_mid");
        tick();
        rst_n = 1'b1;
        tick();
        push_one(32'h5, 26'h2, fill(32'h77));
        chk("rst_mid_awid", c_awid_o, 16'h0);
        chk("rst_mid_awaddr", c_awaddr_o, 64'h0000000500000080);

        // Randomised run against a queue-based model
        begin
            evict_entry_t q[$];
            evict_entry_t e;
            int naw, nw;
            logic err_m;
            logic [ID_W-1:0] idc;
            logic exp_ready, exp_aw, exp_w, exp_b, exp_hit;
            logic [DATA_W-1:0] exp_data;
            logic f_push, f_aw, f_w, f_b;
            do_reset();
            naw = 0; nw = 0; err_m = 1'b0; idc = '0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                ev_valid_i  = ($urandom % 2) == 0;
                ev_tag_i    = TAG_W'($urandom_range(0, 3));
                ev_index_i  = INDEX_W'($urandom_range(0, 1));
                ev_data_i   = rnd512();
                c_awready_i = ($urandom % 3) != 0;
                c_wready_i  = ($urandom % 3) != 0;
                c_bvalid_i  = ($urandom % 2) == 0;
                c_bid_i     = (q.size() > 0 && ($urandom % 32) != 0) ? q[0].id : ID_W'($urandom);
                chk_tag_i   = TAG_W'($urandom_range(0, 3));
                chk_index_i = INDEX_W'($urandom_range(0, 1));
                #1;
                exp_ready = q.size() < DEPTH;
                exp_aw    = naw < q.size();
                exp_w     = nw < q.size();
                exp_b     = naw > 0 && nw > 0;
                exp_hit   = 1'b0;
                exp_data  = '0;
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (!exp_hit && q[i].tag == chk_tag_i && q[i].index == chk_index_i) begin
                        exp_hit  = 1'b1;
                        exp_data = q[i].data;
                    end
                end
                chk("rnd_ev_ready", ev_ready_o, exp_ready);
                chk("rnd_awvalid", c_awvalid_o, exp_aw);
                chk("rnd_wvalid", c_wvalid_o, exp_w);
                chk("rnd_bready", c_bready_o, exp_b);
                chk("rnd_busy", busy_o, q.size() != 0);
                chk("rnd_err", err_o, err_m);
                chk("rnd_hit", chk_hit_o, exp_hit);
                chk("rnd_chk_data", chk_data_o, exp_data);
                if (exp_aw) begin
                    chk("rnd_awid", c_awid_o, q[naw].id);
                    chk("rnd_awaddr", c_awaddr_o, line_addr(q[naw].tag, q[naw].index));
                end
                if (exp_w) begin
                    chk("rnd_wid", c_wid_o, q[nw].id);
                    chk("rnd_wdata", c_wdata_o, q[nw].data);
                end
                f_push = ev_valid_i & exp_ready;
                f_aw   = exp_aw & c_awready_i;
                f_w    = exp_w & c_wready_i;
                f_b    = exp_b & c_bvalid_i;
                e.tag = ev_tag_i; e.index = ev_index_i; e.data = ev_data_i; e.id = idc;
                tick();
                if (f_aw) naw++;
                if (f_w) nw++;
                if (f_b) begin
                    if (c_bid_i != q[0].id) err_m = 1'b1;
                    void'(q.pop_front());
                    naw--;
                    nw--;
                end
                if (f_push) begin
                    q.push_back(e);
                    idc++;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
